// File: rtl/shift_count_register.sv
// shift_count_register: CLR/LD/INC/DEC plus bit-serial shift/rotate.
// Optional macro SHIFT_COUNT_REGISTER_SAT_EN makes INC/DEC saturate.
module shift_count_register #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [2:0]             op,
  input  logic [1:0]             mode,
  input  logic                   fill_in,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   busy,
  output logic                   done,
  output logic                   carry,
  output logic                   zero
);

  localparam logic [2:0] OP_CLR = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE =
    SHAMT_WIDTH'(1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_dout;
  logic [DATA_WIDTH-1:0]  w_dout_nxt;
  logic                   r_carry;
  logic                   w_carry_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic [SHAMT_WIDTH-1:0] w_cnt_nxt;
  logic                   r_right;
  logic                   w_right_nxt;
  logic [1:0]             r_mode;
  logic [1:0]             w_mode_nxt;
  logic                   r_fill;
  logic                   w_fill_nxt;

  logic                   w_idle;
  logic                   w_s_right;
  logic [1:0]             w_s_mode;
  logic                   w_s_fill;
  logic [DATA_WIDTH:0]    w_step;

  // One bit of shift; returns {bit shifted out, new value}.
  function automatic logic [DATA_WIDTH:0] f_step(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  right,
    input logic [1:0]            m,
    input logic                  f
  );
    logic b;
    if (right) begin
      unique case (m)
        2'b01:   b = v[DATA_WIDTH-1];
        2'b10:   b = v[0];
        default: b = f;
      endcase
      return {v[0], b, v[DATA_WIDTH-1:1]};
    end else begin
      unique case (m)
        2'b01:   b = 1'b0;
        2'b10:   b = v[DATA_WIDTH-1];
        default: b = f;
      endcase
      return {v[DATA_WIDTH-1], v[DATA_WIDTH-2:0], b};
    end
  endfunction

  assign w_idle    = (r_state == S_IDLE);
  assign w_s_right = w_idle ? (op == OP_SHR) : r_right;
  assign w_s_mode  = w_idle ? mode : r_mode;
  assign w_s_fill  = w_idle ? fill_in : r_fill;
  assign w_step    = f_step(r_dout, w_s_right,
                            w_s_mode, w_s_fill);

  assign op_ready = w_idle;
  assign busy     = (r_state == S_SHIFT);
  assign dout     = r_dout;
  assign carry    = r_carry;
  assign done     = r_done;
  assign zero     = (r_dout == '0);

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    w_carry_nxt = r_carry;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_right_nxt = r_right;
    w_mode_nxt  = r_mode;
    w_fill_nxt  = r_fill;
    unique case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          w_done_nxt = 1'b1;
          unique case (op)
            OP_CLR: begin
              w_dout_nxt  = '0;
              w_carry_nxt = 1'b0;
            end
            OP_LD: begin
              w_dout_nxt  = din;
              w_carry_nxt = 1'b0;
            end
            OP_INC: begin
`ifdef SHIFT_COUNT_REGISTER_SAT_EN
              w_carry_nxt = &r_dout;
              if (!(&r_dout))
                w_dout_nxt = r_dout + 1'b1;
`else
              w_carry_nxt = &r_dout;
              w_dout_nxt  = r_dout + 1'b1;
`endif
            end
            OP_DEC: begin
`ifdef SHIFT_COUNT_REGISTER_SAT_EN
              w_carry_nxt = (r_dout == '0);
              if (r_dout != '0)
                w_dout_nxt = r_dout - 1'b1;
`else
              w_carry_nxt = (r_dout == '0);
              w_dout_nxt  = r_dout - 1'b1;
`endif
            end
            OP_SHR, OP_SHL: begin
              if (shamt != '0) begin
                w_dout_nxt  = w_step[DATA_WIDTH-1:0];
                w_carry_nxt = w_step[DATA_WIDTH];
                w_cnt_nxt   = shamt - CNT_ONE;
                w_right_nxt = (op == OP_SHR);
                w_mode_nxt  = mode;
                w_fill_nxt  = fill_in;
                if (shamt != CNT_ONE) begin
                  w_state_nxt = S_SHIFT;
                  w_done_nxt  = 1'b0;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_SHIFT: begin
        w_dout_nxt  = w_step[DATA_WIDTH-1:0];
        w_carry_nxt = w_step[DATA_WIDTH];
        w_cnt_nxt   = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers, reset aborts any shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dout  <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_right <= 1'b0;
      r_mode  <= 2'b00;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dout  <= w_dout_nxt;
      r_carry <= w_carry_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_right <= w_right_nxt;
      r_mode  <= w_mode_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

endmodule

// File: tb/tb_shift_count_register.sv
// tb_shift_count_register: vector table, corner sequences,
// and random ops against a behavioural model.
module tb_shift_count_register;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [2:0]   op = 3'd0;
  logic [1:0]   mode = 2'd0;
  logic         fill_in = 1'b0;
  logic [S-1:0] shamt = '0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         busy;
  logic         done;
  logic         carry;
  logic         zero;

  int n_cmp = 0;
  int n_bad = 0;

  shift_count_register #(
    .DATA_WIDTH(W),
    .SHAMT_WIDTH(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op(op),
    .mode(mode),
    .fill_in(fill_in),
    .shamt(shamt),
    .din(din),
    .dout(dout),
    .busy(busy),
    .done(done),
    .carry(carry),
    .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [1:0]   mode;
    logic         fill;
    logic [S-1:0] shamt;
    logic [W-1:0] din;
    logic [W-1:0] exp_dout;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [1:0] m,
                       input logic f,
                       input logic [S-1:0] k,
                       input logic [W-1:0] d);
    op = o; mode = m; fill_in = f;
    shamt = k; din = d;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Whole-shift reference: k single-bit moves by arithmetic.
  task automatic m_shift(inout logic [W-1:0] v,
                         inout logic c,
                         input bit right,
                         input logic [1:0] m,
                         input logic f,
                         input int k);
    logic b;
    for (int i = 0; i < k; i++) begin
      if (right) begin
        c = v[0];
        b = (m == 2'b01) ? v[W-1] :
            (m == 2'b10) ? v[0] : f;
        v = (v >> 1) | ({{(W-1){1'b0}}, b} << (W-1));
      end else begin
        c = v[W-1];
        b = (m == 2'b01) ? 1'b0 :
            (m == 2'b10) ? v[W-1] : f;
        v = (v << 1) | {{(W-1){1'b0}}, b};
      end
    end
  endtask

  task automatic model(inout logic [W-1:0] v,
                       inout logic c,
                       input logic [2:0] o,
                       input logic [1:0] m,
                       input logic f,
                       input int k,
                       input logic [W-1:0] d);
    logic [W-1:0] ones;
    ones = '1;
    case (o)
      3'd1: begin v = 0; c = 0; end
      3'd2: begin v = d; c = 0; end
      3'd3: begin
        c = (v == ones);
`ifdef SHIFT_COUNT_REGISTER_SAT_EN
        if (v != ones) v = v + 1;
`else
        v = v + 1;
`endif
      end
      3'd4: begin
        c = (v == 0);
`ifdef SHIFT_COUNT_REGISTER_SAT_EN
        if (v != 0) v = v - 1;
`else
        v = v - 1;
`endif
      end
      3'd5: m_shift(v, c, 1'b1, m, f, k);
      3'd6: m_shift(v, c, 1'b0, m, f, k);
      default: ;
    endcase
  endtask

  function automatic int exp_lat(input logic [2:0] o,
                                 input int k);
    if ((o == 3'd5 || o == 3'd6) && k >= 2)
      return k - 1;
    return 0;
  endfunction

  initial begin
    int cyc;
    int dn;
    logic [W-1:0] mv;
    logic mc;
    logic [2:0] ro;
    logic [1:0] rm;
    logic rf;
    logic [S-1:0] rk;
    logic [W-1:0] rd;

    vecs.push_back('{3'd2, 2'd0, 1'b0, 4'd0, 16'h8001,
                     16'h8001, 1'b0});
    vecs.push_back('{3'd5, 2'd1, 1'b0, 4'd3, 16'h0,
                     16'hF000, 1'b0});
    vecs.push_back('{3'd2, 2'd0, 1'b0, 4'd0, 16'h8001,
                     16'h8001, 1'b0});
    vecs.push_back('{3'd6, 2'd2, 1'b0, 4'd1, 16'h0,
                     16'h0003, 1'b1});
    vecs.push_back('{3'd2, 2'd0, 1'b0, 4'd0, 16'hFFFF,
                     16'hFFFF, 1'b0});
`ifdef SHIFT_COUNT_REGISTER_SAT_EN
    vecs.push_back('{3'd3, 2'd0, 1'b0, 4'd0, 16'h0,
                     16'hFFFF, 1'b1});
`else
    vecs.push_back('{3'd3, 2'd0, 1'b0, 4'd0, 16'h0,
                     16'h0000, 1'b1});
`endif
    vecs.push_back('{3'd1, 2'd0, 1'b0, 4'd0, 16'h0,
                     16'h0000, 1'b0});
`ifdef SHIFT_COUNT_REGISTER_SAT_EN
    vecs.push_back('{3'd4, 2'd0, 1'b0, 4'd0, 16'h0,
                     16'h0000, 1'b1});
`else
    vecs.push_back('{3'd4, 2'd0, 1'b0, 4'd0, 16'h0,
                     16'hFFFF, 1'b1});
`endif
    vecs.push_back('{3'd2, 2'd0, 1'b0, 4'd0, 16'h0001,
                     16'h0001, 1'b0});
    vecs.push_back('{3'd6, 2'd3, 1'b1, 4'd2, 16'h0,
                     16'h0007, 1'b0});
    vecs.push_back('{3'd2, 2'd0, 1'b0, 4'd0, 16'hA5A5,
                     16'hA5A5, 1'b0});
    vecs.push_back('{3'd6, 2'd2, 1'b0, 4'd15, 16'h0,
                     16'hD2D2, 1'b0});
    vecs.push_back('{3'd7, 2'd0, 1'b0, 4'd0, 16'h0,
                     16'hD2D2, 1'b0});
    vecs.push_back('{3'd5, 2'd0, 1'b0, 4'd0, 16'h0,
                     16'hD2D2, 1'b0});
    vecs.push_back('{3'd3, 2'd0, 1'b0, 4'd0, 16'h0,
                     16'hD2D3, 1'b0});
    vecs.push_back('{3'd5, 2'd0, 1'b1, 4'd4, 16'h0,
                     16'hFD2D, 1'b0});
    vecs.push_back('{3'd4, 2'd0, 1'b0, 4'd0, 16'h0,
                     16'hFD2C, 1'b0});
    vecs.push_back('{3'd6, 2'd1, 1'b0, 4'd2, 16'h0,
                     16'hF4B0, 1'b1});
    vecs.push_back('{3'd5, 2'd1, 1'b0, 4'd1, 16'h0,
                     16'hFA58, 1'b0});

    tick();
    tick();
    rst = 1'b0;
    chk("rst_dout", dout, 0);
    chk("rst_carry", carry, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", op_ready, 1);
    chk("rst_zero", zero, 1);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].mode, vecs[i].fill,
            vecs[i].shamt, vecs[i].din);
      wait_done(cyc);
      chk($sformatf("vec%0d_lat", i), cyc,
          exp_lat(vecs[i].op, int'(vecs[i].shamt)));
      chk($sformatf("vec%0d_dout", i), dout,
          vecs[i].exp_dout);
      chk($sformatf("vec%0d_carry", i), carry,
          vecs[i].exp_carry);
      chk($sformatf("vec%0d_zero", i), zero,
          vecs[i].exp_dout == 0);
      tick();
    end

    issue(3'd2, 2'd0, 1'b0, 4'd0, 16'h8001);
    issue(3'd5, 2'd1, 1'b0, 4'd3, 16'h0);
    chk("asr_s1_dout", dout, 16'hC000);
    chk("asr_s1_busy", busy, 1);
    chk("asr_s1_done", done, 0);
    tick();
    chk("asr_s2_dout", dout, 16'hE000);
    chk("asr_s2_busy", busy, 1);
    tick();
    chk("asr_s3_dout", dout, 16'hF000);
    chk("asr_s3_busy", busy, 0);
    chk("asr_s3_done", done, 1);
    chk("asr_s3_ready", op_ready, 1);
    chk("asr_s3_carry", carry, 0);
    tick();
    chk("asr_after_done", done, 0);

    issue(3'd2, 2'd0, 1'b0, 4'd0, 16'h00FF);
    op = 3'd6; mode = 2'd0; fill_in = 1'b1;
    shamt = 4'd10; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_mid_dout", dout, 16'h0FFF);
    chk("abort_mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_dout", dout, 0);
    chk("abort_ready", op_ready, 1);
    chk("abort_carry", carry, 0);
    chk("abort_busy", busy, 0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dn++;
      tick();
    end
    chk("abort_no_done", dn, 0);

    issue(3'd2, 2'd0, 1'b0, 4'd0, 16'h0001);
    op = 3'd6; mode = 2'd0; fill_in = 1'b0;
    shamt = 4'd4; op_valid = 1'b1;
    tick();
    op = 3'd2; din = 16'h1234;
    chk("hold_s1_dout", dout, 16'h0002);
    chk("hold_s1_ready", op_ready, 0);
    tick();
    chk("hold_s2_dout", dout, 16'h0004);
    tick();
    chk("hold_s3_dout", dout, 16'h0008);
    tick();
    chk("hold_s4_dout", dout, 16'h0010);
    chk("hold_s4_done", done, 1);
    chk("hold_s4_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    chk("hold_ld_dout", dout, 16'h1234);
    chk("hold_ld_done", done, 1);
    issue(3'd5, 2'd0, 1'b0, 4'd0, 16'h0);
    chk("shr0_done", done, 1);
    chk("shr0_dout", dout, 16'h1234);
    tick();

    mv = dout;
    mc = carry;
    for (int n = 0; n < 300; n++) begin
      ro = 3'($urandom_range(0, 7));
      rm = 2'($urandom_range(0, 3));
      rf = 1'($urandom_range(0, 1));
      rk = S'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: rd = '1;
        1: rd = '0;
        default: rd = W'($urandom);
      endcase
      issue(ro, rm, rf, rk, rd);
      wait_done(cyc);
      model(mv, mc, ro, rm, rf, int'(rk), rd);
      chk($sformatf("rnd%0d_lat op%0d", n, ro), cyc,
          exp_lat(ro, int'(rk)));
      chk($sformatf("rnd%0d_dout op%0d", n, ro),
          dout, mv);
      chk($sformatf("rnd%0d_carry op%0d", n, ro),
          carry, mc);
      chk($sformatf("rnd%0d_zero", n), zero, mv == 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
